alu_regfile_datapath: RTL and testbench
=======================================

Name: alu_regfile_datapath

Overview:
- Execution datapath: a 16-entry x 32-bit register bank with two combinational read ports and one clocked write port.
- The two read ports drive a combinational ALU (A = read port 1, B = read port 2).
- The ALU result can be written back into the bank in place of external write data.
- Sits between instruction decode (supplies register indices, opcode and write controls) and the processor's writeback/next-stage logic.

Parameters:
- DATA_W, 32, datapath and register width.
- ADDR_W, 4, register index width.
- NUM_REGS, 16, number of registers (2**ADDR_W).

Ports:
- clk  in  1  single clock; all register writes occur on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- read_reg1  in  ADDR_W  index for read port 1 (ALU operand A).
- read_reg2  in  ADDR_W  index for read port 2 (ALU operand B).
- write_reg  in  ADDR_W  destination register index.
- write_data  in  DATA_W  external write data.
- write_enable  in  1  write strobe, sampled at the clk rising edge.
- wb_sel  in  1  write source select: 0 = write_data, 1 = alu_result.
- opcode  in  4  ALU operation select.
- data_out1  out  DATA_W  contents of registers[read_reg1].
- data_out2  out  DATA_W  contents of registers[read_reg2].
- alu_result  out  DATA_W  ALU result.
- zero  out  1  high when alu_result == 0.
- carry  out  1  carry out (ADD) / borrow (SUB); 0 for all other ops.
- overflow  out  1  signed overflow for ADD/SUB; 0 for all other ops.

Behaviour:
- Reset (rst_n low, asynchronous): register i is loaded with value i (R0=0, R1=1 ... R15=15); held while rst_n is low.
- Outputs after reset are combinational from the reset contents, so data_out1/data_out2 show the loaded values immediately.
- Write: on the clk rising edge with rst_n high and write_enable=1, registers[write_reg] is loaded with the selected source (write_data or alu_result). The source is sampled before the edge.
- Every register, R0 included, is writable; there is no hardwired zero.
- Reads are purely combinational; read latency is zero.
- Read-during-write (same index): the read returns the old value until the clock edge, then the new value. There is no bypass.
- Writeback with wb_sel=1 uses the pre-edge alu_result. A write to a source register therefore takes effect one cycle later with no combinational loop.
- ALU is combinational. A = data_out1, B = data_out2. All results are DATA_W wide and truncated:
  - 0000 ADD: A+B. carry = bit DATA_W of the sum. overflow = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
  - 0001 SUB: A-B. carry = borrow (A<B unsigned). overflow = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
  - 0010 AND: A&B.
  - 0011 OR: A|B.
  - 0100 XOR: A^B.
  - 0101 SL: A<<1, zero fill.
  - 0110 SRL: A>>1, zero fill.
  - 0111 SRA: A>>>1, msb replicated.
  - 1000-1111: result 0 (zero=1, carry=0, overflow=0).
- Reset asserted mid-operation: an in-flight write is discarded and the bank returns to the reset pattern.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SRL, OP_SRA;
  - DATA_W/ADDR_W defaults.
- One natural sub-module, alu_core: the purely combinational ALU with flags.
- The register bank and writeback mux live in the top.

Test Plan:
- Reset -> read_reg1=1, read_reg2=9 gives data_out1=0x00000001, data_out2=0x00000009. Then write_enable=1, wb_sel=0, write_reg=3, write_data=100 for one edge -> registers[3]=0x00000064.
- A=R1=1, B=R9=9 across the ALU ops:
  - ADD -> 0x0000000A, carry=0.
  - SUB -> 0xFFFFFFF8, carry=1.
  - AND -> 0x00000001.
  - OR -> 0x00000009.
  - XOR -> 0x00000008.
  - SL -> 0x00000002.
  - SRL -> 0x00000000, zero=1.
- Load R2=0x80000000 and use it as A:
  - SRA -> 0xC0000000.
  - SRL -> 0x40000000.
  - With B=R2, ADD -> 0x00000000, carry=1, overflow=1, zero=1.
- Writeback: wb_sel=1, write_reg=3, opcode=ADD, A=R1, B=R9 -> after the edge R3=0x0000000A. Read of R3 in the same cycle before the edge returns the old value.
- Read-during-write: read_reg1=5 while writing 0xDEADBEEF to R5 -> data_out1=5 before the edge, 0xDEADBEEF after it.
- Reset mid-write: rst_n low asynchronously between edges after R3 was written -> R3 reads 0x00000003 immediately. A write_enable pulse while rst_n is low has no effect.

Source files
------------

// File: rtl/alu_regfile_datapath_pkg.sv
// Shared constants for the ALU/register-bank datapath: default widths and ALU opcodes.
package alu_regfile_datapath_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned OPCODE_W   = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_SL  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_SRL = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_SRA = 4'b0111;

endpackage

// File: rtl/alu_regfile_datapath_alu_core.sv
// Purely combinational ALU with zero/carry/overflow flags.
module alu_core
    import alu_regfile_datapath_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [DATA_W-1:0]   result,
    output logic                zero,
    output logic                carry,
    output logic                overflow
);

    logic [DATA_W:0] wide;

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        wide     = '0;
        case (opcode)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                result   = wide[DATA_W-1:0];
                carry    = wide[DATA_W];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is set exactly when a < b (borrow).
                wide     = {1'b0, a} - {1'b0, b};
                result   = wide[DATA_W-1:0];
                carry    = wide[DATA_W];
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SL:  result = {a[DATA_W-2:0], 1'b0};
            OP_SRL: result = {1'b0, a[DATA_W-1:1]};
            OP_SRA: result = {a[DATA_W-1], a[DATA_W-1:1]};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_regfile_datapath.sv
// Register bank (2 comb read ports, 1 clocked write port) feeding an ALU, with ALU writeback.
module alu_regfile_datapath
    import alu_regfile_datapath_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   read_reg1,
    input  logic [ADDR_W-1:0]   read_reg2,
    input  logic [ADDR_W-1:0]   write_reg,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                write_enable,
    input  logic                wb_sel,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [DATA_W-1:0]   data_out1,
    output logic [DATA_W-1:0]   data_out2,
    output logic [DATA_W-1:0]   alu_result,
    output logic                zero,
    output logic                carry,
    output logic                overflow
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] wb_data;

    assign data_out1 = regs_q[read_reg1];
    assign data_out2 = regs_q[read_reg2];

    // alu_result is sampled at the edge, so self-referencing writeback has no comb loop.
    assign wb_data = wb_sel ? alu_result : write_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else if (write_enable) begin
            regs_q[write_reg] <= wb_data;
        end
    end

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .a        (data_out1),
        .b        (data_out2),
        .opcode   (opcode),
        .result   (alu_result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed self-checking bench for alu_regfile_datapath.
module tb_alu_regfile_datapath;

    logic        clk;
    logic        rst_n;
    logic [3:0]  read_reg1;
    logic [3:0]  read_reg2;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic        write_enable;
    logic        wb_sel;
    logic [3:0]  opcode;
    logic [31:0] data_out1;
    logic [31:0] data_out2;
    logic [31:0] alu_result;
    logic        zero;
    logic        carry;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    alu_regfile_datapath u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable),
        .wb_sel       (wb_sel),
        .opcode       (opcode),
        .data_out1    (data_out1),
        .data_out2    (data_out2),
        .alu_result   (alu_result),
        .zero         (zero),
        .carry        (carry),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic alu_check(input string tag, input logic [3:0] op, input logic [31:0] exp_res,
                             input logic exp_z, input logic exp_c, input logic exp_v);
        opcode = op;
        #1;
        check({tag, " result"}, alu_result, exp_res);
        check({tag, " zero"}, {31'b0, zero}, {31'b0, exp_z});
        check({tag, " carry"}, {31'b0, carry}, {31'b0, exp_c});
        check({tag, " overflow"}, {31'b0, overflow}, {31'b0, exp_v});
    endtask

    // Single external write of one edge; leaves write_enable low afterwards.
    task automatic write_ext(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        write_reg    = idx;
        write_data   = val;
        wb_sel       = 1'b0;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        read_reg1    = 4'd0;
        read_reg2    = 4'd0;
        write_reg    = 4'd0;
        write_data   = 32'd0;
        write_enable = 1'b0;
        wb_sel       = 1'b0;
        opcode       = 4'd0;
        #12;
        rst_n = 1'b1;

        // Reset contents
        read_reg1 = 4'd1;
        read_reg2 = 4'd9;
        #1;
        check("reset r1", data_out1, 32'h1);
        check("reset r9", data_out2, 32'h9);
        read_reg1 = 4'd0;
        read_reg2 = 4'd15;
        #1;
        check("reset r0", data_out1, 32'h0);
        check("reset r15", data_out2, 32'hF);

        // External write to R3, observed before and after the edge
        @(negedge clk);
        read_reg1    = 4'd3;
        write_reg    = 4'd3;
        write_data   = 32'd100;
        wb_sel       = 1'b0;
        write_enable = 1'b1;
        #1;
        check("r3 before write", data_out1, 32'h3);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("r3 after write", data_out1, 32'h64);

        // R0 is writable
        write_ext(4'd0, 32'h5A5A_0000);
        read_reg1 = 4'd0;
        #1;
        check("r0 writable", data_out1, 32'h5A5A_0000);

        // ALU with A=R1=1, B=R9=9
        read_reg1 = 4'd1;
        read_reg2 = 4'd9;
        alu_check("add 1+9", 4'b0000, 32'h0000_000A, 1'b0, 1'b0, 1'b0);
        alu_check("sub 1-9", 4'b0001, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0);
        alu_check("and", 4'b0010, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        alu_check("or", 4'b0011, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
        alu_check("xor", 4'b0100, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        alu_check("sl", 4'b0101, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        alu_check("srl 1", 4'b0110, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        alu_check("op 1000", 4'b1000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        alu_check("op 1111", 4'b1111, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

        // Sign-bit operand in R2
        write_ext(4'd2, 32'h8000_0000);
        read_reg1 = 4'd2;
        read_reg2 = 4'd2;
        alu_check("sra msb", 4'b0111, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
        alu_check("srl msb", 4'b0110, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        alu_check("add msb+msb", 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        alu_check("sub msb-msb", 4'b0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        read_reg1 = 4'd1;
        alu_check("sub 1-msb", 4'b0001, 32'h8000_0001, 1'b0, 1'b1, 1'b1);
        alu_check("sl 1 r9", 4'b0101, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

        // ALU writeback into R3
        @(negedge clk);
        read_reg1    = 4'd1;
        read_reg2    = 4'd9;
        opcode       = 4'b0000;
        write_reg    = 4'd3;
        wb_sel       = 1'b1;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_reg1    = 4'd3;
        #1;
        check("wb r3", data_out1, 32'h0000_000A);

        // Writeback into a source register: old value until the edge, no loop after
        @(negedge clk);
        read_reg1    = 4'd1;
        read_reg2    = 4'd9;
        opcode       = 4'b0000;
        write_reg    = 4'd9;
        wb_sel       = 1'b1;
        write_enable = 1'b1;
        #1;
        check("wb self pre r9", data_out2, 32'h9);
        check("wb self pre alu", alu_result, 32'hA);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("wb self post r9", data_out2, 32'hA);
        check("wb self post alu", alu_result, 32'hB);

        // Read-during-write on R5
        @(negedge clk);
        read_reg1    = 4'd5;
        write_reg    = 4'd5;
        write_data   = 32'hDEAD_BEEF;
        wb_sel       = 1'b0;
        write_enable = 1'b1;
        #1;
        check("rdw r5 before", data_out1, 32'h5);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("rdw r5 after", data_out1, 32'hDEAD_BEEF);

        // Asynchronous reset between edges with a write pending
        @(negedge clk);
        read_reg1    = 4'd3;
        read_reg2    = 4'd5;
        write_reg    = 4'd3;
        write_data   = 32'h0000_1234;
        wb_sel       = 1'b0;
        write_enable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst r3", data_out1, 32'h3);
        check("async rst r5", data_out2, 32'h5);
        @(posedge clk);
        #1;
        check("we in rst r3", data_out1, 32'h3);
        @(negedge clk);
        write_enable = 1'b0;
        rst_n        = 1'b1;
        read_reg1    = 4'd9;
        read_reg2    = 4'd0;
        #1;
        check("post rst r9", data_out1, 32'h9);
        check("post rst r0", data_out2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
